mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Single-port byte-serial memory controller between the core and the external RAM/IO bus.
- Directly downstream of the load/store buffer; also serves the instruction-fetch unit.
- Arbitrates two requesters: LSB has priority over fetch.
- Splits 1/2/4-byte accesses into byte cycles, assembles little-endian read data, returns a one-cycle done pulse.

Parameters:
- ADDR_W, 32, address width on all ports.
- IO_HI, 2'b11, value of addr[17:16] that marks the memory-mapped IO window.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset
- rdy_in  in  1  global ready; low freezes all state and outputs
- clear  in  1  pipeline flush (branch mispredict)
- data_r_en  in  1  LSB load request, held high until LSB_en_o seen
- data_w_en  in  1  LSB store request, held high until LSB_en_o seen
- data_addr  in  32  LSB byte address
- data_val  in  32  LSB store data, little-endian
- data_len  in  32  access length in bytes: 1, 2 or 4
- LSB_en_o  out  1  LSB done pulse
- LSB_data_o  out  32  load data, zero-extended
- inst_r_en  in  1  fetch request, held until inst_en_o seen
- inst_addr  in  32  fetch address
- inst_en_o  out  1  fetch done pulse
- inst_data_o  out  32  fetched word
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe, 1 = write
- io_buffer_full  in  1  IO output FIFO full

Behaviour:
- One clock, clk_in. Reset is synchronous and active-high on rst_in.
- Reset values: all outputs 0; state IDLE; byte counter 0.
- rdy_in low: hold every register. A reset still applies on that edge.
- States:
  - IDLE: idle.
  - LREAD: LSB load.
  - LWRITE: LSB store.
  - FETCH: instruction fetch, 4 bytes.
  - COOL: one-cycle pause.
- Acceptance from IDLE, priority order:
  - data_w_en → LWRITE.
  - else data_r_en → LREAD.
  - else inst_r_en (with clear low) → FETCH.
- On acceptance at edge A, latch addr, len (and val for stores); drive mem_a = addr.
- Requests are ignored in every state except IDLE.
- RAM timing: the byte for the address on mem_a in one cycle is valid on mem_din in the next cycle.
- Read of n bytes:
  - Byte k address is driven after edge A+k.
  - Byte k is sampled at edge A+k+2 into bits [8k+7:8k].
  - Done pulse and data register at edge A+n+1 (last byte taken directly from mem_din).
  - Examples: lb done at A+2; lw/fetch done at A+5.
- Write of n bytes:
  - mem_wr=1, mem_a=addr+k, mem_dout=val[8k+7:8k] after edge A+k.
  - Done at edge A+n with mem_wr=0.
- IO stall: a write byte whose addr[17:16]==IO_HI is held back while io_buffer_full=1.
  - During the stall mem_wr=0 and the counter does not advance.
  - The byte is issued on the first cycle io_buffer_full=0.
- Done: LSB_en_o / inst_en_o high exactly one cycle; data output holds until the next completion.
- COOL:
  - Entered after every completion, for exactly one cycle, then IDLE.
  - Absorbs the requester's registered deassert, so a request still high on the edge after done is not re-accepted.
- clear:
  - In FETCH: abort immediately → IDLE, mem_a/mem_wr idle, no inst_en_o.
  - In LREAD: abort → IDLE, no LSB_en_o.
  - In LWRITE: the store continues to completion (it is already committed).
  - In IDLE: fetch acceptance is blocked that cycle; LSB requests are still accepted.
- Address arithmetic: addr+k wraps modulo 2^32.
- data_len values other than 1/2/4 are treated as 4.
- Simultaneous LSB request and fetch: LSB wins; fetch waits in IDLE for the next opportunity.

Optional Feature:
- Macro MEMCTRL_FETCH_BUF_EN adds a one-word fetch buffer (tag, word, valid).
- With it defined:
  - Every completed fetch fills the buffer.
  - A fetch accepted in IDLE whose inst_addr equals the valid tag skips RAM: inst_en_o and inst_data_o at edge A+1, then COOL.
  - Any LSB store whose byte range overlaps the tagged word clears valid at store acceptance.
  - Reset clears valid; clear does not.
- Without it: every fetch goes to RAM (done at A+5).

Test Plan:
- lw at 0x100, RAM bytes 11,22,33,44 → LSB_en_o at A+5, LSB_data_o=0x44332211, one-cycle pulse, no re-accept in COOL.
- sh to 0x200, data_val=0xABCD → mem_wr at A and A+1, bytes CD then AB; LSB_en_o at A+2.
- sb to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for those cycles; byte issued after release; done 3 cycles late.
- data_r_en and inst_r_en raised together → load served first; fetch starts after COOL, inst_en_o with correct word.
- clear in cycle 2 of a fetch → no inst_en_o, IDLE next cycle. clear during a sw → all 4 bytes still written.
- With MEMCTRL_FETCH_BUF_EN: two fetches of 0x0 → second done at A+1. A sw to 0x0 between them → second fetch back to A+5.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO controller arbitrating LSB (priority) and instruction fetch.
// Define MEMCTRL_FETCH_BUF_EN to add a one-word fetch buffer that short-circuits repeat fetches.
module mem_ctrl #(
  parameter int         ADDR_W = 32,
  parameter logic [1:0] IO_HI  = 2'b11
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear,
  input  logic              data_r_en,
  input  logic              data_w_en,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_val,
  input  logic [31:0]       data_len,
  output logic              LSB_en_o,
  output logic [31:0]       LSB_data_o,
  input  logic              inst_r_en,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_en_o,
  output logic [31:0]       inst_data_o,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  typedef enum logic [2:0] {IDLE, LREAD, LWRITE, FETCH, COOL} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr_q, acc_addr, wa;
  logic [31:0] val_q, rbuf, merged, f_data;
  logic [2:0] n_q, n_in, cnt, wk;
  logic r_last, f_last, w_last, hit_q, fb_hit;
  // cnt counts edges since acceptance for reads, and is the byte index on the bus for writes
  always_comb begin
    n_in = data_len == 32'd1 ? 3'd1 : data_len == 32'd2 ? 3'd2 : 3'd4;
    acc_addr = state_nx == FETCH ? inst_addr : data_addr;
    merged = cnt[1:0] == 2'd1 ? {rbuf[31:8], mem_din} :
             cnt[1:0] == 2'd2 ? {rbuf[31:16], mem_din, rbuf[7:0]} :
             cnt[1:0] == 2'd3 ? {rbuf[31:24], mem_din, rbuf[15:0]} :
                                {mem_din, rbuf[23:0]};
    r_last = cnt == n_q;
    f_last = hit_q || r_last;
    w_last = mem_wr && cnt + 3'd1 == n_q;
    wk = mem_wr ? cnt + 3'd1 : cnt;
    wa = addr_q + ADDR_W'(wk);
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = data_w_en ? LWRITE : data_r_en ? LREAD : (inst_r_en && !clear) ? FETCH : IDLE;
      LREAD:   state_nx = clear ? IDLE : r_last ? COOL : LREAD;
      FETCH:   state_nx = clear ? IDLE : f_last ? COOL : FETCH;
      LWRITE:  state_nx = w_last ? COOL : LWRITE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_in)
    if (rst_in) state <= IDLE;
    else if (rdy_in) state <= state_nx;
`ifdef MEMCTRL_FETCH_BUF_EN
  logic              fb_valid;
  logic [ADDR_W-1:0] fb_tag, d_lo, d_hi;
  logic [31:0]       fb_word;
  always_comb begin
    fb_hit = fb_valid && inst_addr == fb_tag;
    f_data = hit_q ? fb_word : merged;
    d_lo = data_addr - fb_tag;
    d_hi = fb_tag - data_addr;
  end
  // modular distances make the store/word overlap test correct across address wrap
  always_ff @(posedge clk_in)
    if (rst_in) begin
      fb_valid <= 1'b0;
      hit_q <= 1'b0;
      fb_tag <= '0;
      fb_word <= '0;
    end else if (rdy_in) begin
      if (state == IDLE && state_nx == FETCH) hit_q <= fb_hit;
      if (state == IDLE && state_nx == LWRITE && (d_lo < ADDR_W'(4) || d_hi < ADDR_W'(n_in))) fb_valid <= 1'b0;
      if (state == FETCH && state_nx == COOL) begin
        fb_valid <= 1'b1;
        fb_tag <= addr_q;
        fb_word <= f_data;
      end
    end
`else
  assign fb_hit = 1'b0;
  assign hit_q = 1'b0;
  assign f_data = merged;
`endif
  always_ff @(posedge clk_in)
    if (rst_in) begin
      addr_q <= '0;
      val_q <= '0;
      n_q <= '0;
      cnt <= '0;
      rbuf <= '0;
      mem_a <= '0;
      mem_dout <= '0;
      mem_wr <= 1'b0;
      LSB_en_o <= 1'b0;
      LSB_data_o <= '0;
      inst_en_o <= 1'b0;
      inst_data_o <= '0;
    end else if (rdy_in) begin
      LSB_en_o <= 1'b0;
      inst_en_o <= 1'b0;
      case (state)
        IDLE: if (state_nx != IDLE) begin
          addr_q <= acc_addr;
          val_q <= data_val;
          n_q <= state_nx == FETCH ? 3'd4 : n_in;
          cnt <= '0;
          rbuf <= '0;
          mem_a <= (state_nx == FETCH && fb_hit) ? '0 : acc_addr;
          mem_dout <= data_val[7:0];
          mem_wr <= state_nx == LWRITE && !(acc_addr[17:16] == IO_HI && io_buffer_full);
        end
        LREAD, FETCH: if (!clear) begin
          cnt <= cnt + 3'd1;
          mem_a <= cnt + 3'd1 < n_q ? addr_q + ADDR_W'(cnt + 3'd1) : '0;
          if (cnt != 3'd0) rbuf <= merged;
          if (state == LREAD && r_last) begin
            LSB_en_o <= 1'b1;
            LSB_data_o <= merged;
          end
          if (state == FETCH && f_last) begin
            inst_en_o <= 1'b1;
            inst_data_o <= f_data;
          end
        end
        LWRITE: if (w_last) LSB_en_o <= 1'b1;
        else begin
          cnt <= wk;
          mem_a <= wa;
          mem_dout <= 8'(val_q >> {wk, 3'b000});
          mem_wr <= !(wa[17:16] == IO_HI && io_buffer_full);
        end
        default: ;
      endcase
      if (state_nx == IDLE || state_nx == COOL) begin
        mem_a <= '0;
        mem_wr <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a one-cycle-latency byte RAM and IO sink.
module tb_mem_ctrl;
  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, clear = 1'b0;
  logic        data_r_en = 1'b0, data_w_en = 1'b0, inst_r_en = 1'b0, io_buffer_full = 1'b0;
  logic [31:0] data_addr = '0, data_val = '0, data_len = '0, inst_addr = '0;
  logic [7:0]  mem_din = '0;
  logic        LSB_en_o, inst_en_o, mem_wr;
  logic [31:0] LSB_data_o, inst_data_o, mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  ram [0:65535];
  logic [7:0]  io_last = '0;
  int          io_cnt = 0;
  int          n_cmp = 0, n_bad = 0;
`ifdef MEMCTRL_FETCH_BUF_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 5;
`endif

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear(clear),
    .data_r_en(data_r_en), .data_w_en(data_w_en), .data_addr(data_addr),
    .data_val(data_val), .data_len(data_len), .LSB_en_o(LSB_en_o), .LSB_data_o(LSB_data_o),
    .inst_r_en(inst_r_en), .inst_addr(inst_addr), .inst_en_o(inst_en_o), .inst_data_o(inst_data_o),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk_in = ~clk_in;

  // the external bus stalls together with the core when rdy_in is low
  always @(posedge clk_in)
    if (rdy_in) begin
      mem_din <= ram[mem_a[15:0]];
      if (mem_wr) begin
        if (mem_a[17:16] == 2'b11) begin
          io_last <= mem_dout;
          io_cnt <= io_cnt + 1;
        end else ram[mem_a[15:0]] <= mem_dout;
      end
    end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp, input int lat);
    inst_r_en = 1'b1;
    inst_addr = a;
    tick();
    for (int i = 1; i < lat; i++) begin
      tick();
      chk("fetch_wait", inst_en_o, 0);
    end
    tick();
    chk("fetch_done", inst_en_o, 1);
    chk("fetch_word", inst_data_o, exp);
    inst_r_en = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h0100] = 8'h11; ram[16'h0101] = 8'h22; ram[16'h0102] = 8'h33; ram[16'h0103] = 8'h44;
    ram[16'h0400] = 8'h13; ram[16'h0401] = 8'h05; ram[16'h0402] = 8'h00; ram[16'h0403] = 8'h00;
    ram[16'h0000] = 8'h93; ram[16'h0001] = 8'h00; ram[16'h0002] = 8'h10; ram[16'h0003] = 8'h00;
    tick();
    tick();
    rst_in = 1'b0;
    chk("rst_lsb_en", LSB_en_o, 0);
    chk("rst_inst_en", inst_en_o, 0);
    chk("rst_mem_wr", mem_wr, 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_lsb_data", LSB_data_o, 0);
    chk("rst_inst_data", inst_data_o, 0);
    // lw 0x100
    data_r_en = 1'b1; data_addr = 32'h100; data_len = 4;
    tick(); chk("lw_a0", mem_a, 32'h100);
    tick(); chk("lw_a1", mem_a, 32'h101);
    tick(); tick(); tick(); chk("lw_early", LSB_en_o, 0);
    tick();
    chk("lw_done", LSB_en_o, 1);
    chk("lw_data", LSB_data_o, 32'h44332211);
    chk("lw_no_inst", inst_en_o, 0);
    tick();
    chk("lw_pulse", LSB_en_o, 0);
    chk("lw_cool", mem_a, 0);
    chk("lw_hold", LSB_data_o, 32'h44332211);
    data_r_en = 1'b0;
    tick();
    // sh 0x200
    data_w_en = 1'b1; data_addr = 32'h200; data_val = 32'hABCD; data_len = 2;
    tick();
    chk("sh_wr0", mem_wr, 1); chk("sh_a0", mem_a, 32'h200); chk("sh_d0", mem_dout, 8'hCD);
    tick();
    chk("sh_wr1", mem_wr, 1); chk("sh_a1", mem_a, 32'h201); chk("sh_d1", mem_dout, 8'hAB);
    chk("sh_early", LSB_en_o, 0);
    tick(); chk("sh_done", LSB_en_o, 1); chk("sh_wr_off", mem_wr, 0);
    tick(); chk("sh_cool", mem_wr, 0); chk("sh_pulse", LSB_en_o, 0);
    data_w_en = 1'b0;
    tick();
    chk("sh_ram0", ram[16'h0200], 8'hCD);
    chk("sh_ram1", ram[16'h0201], 8'hAB);
    // sb to IO window with a 3-cycle full stall
    io_buffer_full = 1'b1;
    data_w_en = 1'b1; data_addr = 32'h30000; data_val = 32'h5A; data_len = 1;
    tick(); chk("io_stall0", mem_wr, 0);
    tick(); chk("io_stall1", mem_wr, 0);
    tick(); chk("io_stall2", mem_wr, 0);
    io_buffer_full = 1'b0;
    tick();
    chk("io_wr", mem_wr, 1); chk("io_a", mem_a, 32'h30000); chk("io_d", mem_dout, 8'h5A);
    chk("io_early", LSB_en_o, 0);
    tick(); chk("io_done", LSB_en_o, 1); chk("io_wr_off", mem_wr, 0);
    tick();
    data_w_en = 1'b0;
    tick();
    chk("io_cnt", io_cnt, 1);
    chk("io_byte", io_last, 8'h5A);
    // lb and fetch together: load first
    data_r_en = 1'b1; data_addr = 32'h102; data_len = 1;
    inst_r_en = 1'b1; inst_addr = 32'h400;
    tick(); chk("arb_load_a", mem_a, 32'h102);
    tick();
    tick();
    chk("arb_lb_done", LSB_en_o, 1);
    chk("arb_lb_data", LSB_data_o, 32'h33);
    chk("arb_no_inst", inst_en_o, 0);
    tick(); chk("arb_cool", mem_a, 0);
    data_r_en = 1'b0;
    tick(); chk("arb_fetch_a", mem_a, 32'h400);
    repeat (4) tick();
    chk("arb_fetch_early", inst_en_o, 0);
    tick();
    chk("arb_fetch_done", inst_en_o, 1);
    chk("arb_fetch_word", inst_data_o, 32'h00000513);
    inst_r_en = 1'b0;
    tick();
    // clear aborts a fetch in its second cycle
    inst_r_en = 1'b1; inst_addr = 32'h400;
    tick();
    tick();
    clear = 1'b1;
    tick();
    chk("clr_a", mem_a, 0); chk("clr_wr", mem_wr, 0); chk("clr_inst", inst_en_o, 0);
    tick(); chk("clr_idle_block", mem_a, 0);
    clear = 1'b0; inst_r_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("clr_no_done", inst_en_o, 0);
    end
    // clear does not stop a committed sw
    data_w_en = 1'b1; data_addr = 32'h300; data_val = 32'hDEADBEEF; data_len = 4;
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("sw_clr_wr", mem_wr, 1); chk("sw_clr_a", mem_a, 32'h302);
    tick();
    tick(); chk("sw_clr_done", LSB_en_o, 1);
    tick();
    data_w_en = 1'b0;
    tick();
    chk("sw_clr_ram", {ram[16'h0303], ram[16'h0302], ram[16'h0301], ram[16'h0300]}, 32'hDEADBEEF);
    // rdy_in low freezes a load in flight
    data_r_en = 1'b1; data_addr = 32'h400; data_len = 4;
    tick();
    tick();
    tick(); chk("rdy_a", mem_a, 32'h402);
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_hold_a", mem_a, 32'h402);
      chk("rdy_hold_en", LSB_en_o, 0);
    end
    rdy_in = 1'b1;
    tick();
    tick(); chk("rdy_early", LSB_en_o, 0);
    tick();
    chk("rdy_done", LSB_en_o, 1);
    chk("rdy_data", LSB_data_o, 32'h00000513);
    data_r_en = 1'b0;
    tick();
    // repeat fetch of 0x0, then a store over it forces a RAM refetch
    do_fetch(32'h0, 32'h00100093, 5);
    do_fetch(32'h0, 32'h00100093, HIT_LAT);
    data_w_en = 1'b1; data_addr = 32'h0; data_val = 32'h00200113; data_len = 4;
    tick();
    repeat (3) tick();
    tick(); chk("sw0_done", LSB_en_o, 1);
    data_w_en = 1'b0;
    tick();
    do_fetch(32'h0, 32'h00200113, 5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
